// File: rtl/smart_count_monitor_pkg.sv
// Shared types for the SmartCounter q-bus monitor: FSM states, step classes
// and default widths.
package smart_count_monitor_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int WRAP_W_DEF = 8;
    localparam int HOLD_W_DEF = 4;
    localparam int STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FIRED   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        STEP_NONE = 3'd0,
        STEP_HOLD = 3'd1,
        STEP_INC  = 3'd2,
        STEP_WRAP = 3'd3,
        STEP_JUMP = 3'd4
    } step_e;

endpackage

// File: rtl/smart_count_monitor_if.sv
// Bus between the counter/control side and the monitor: count, threshold,
// FSM controls in; interrupt, state, pulses and wrap tally out.
interface smart_count_monitor_if
    import smart_count_monitor_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int WRAP_W = WRAP_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
);
    logic [WIDTH-1:0]   cnt_q;
    logic [WIDTH-1:0]   threshold;
    logic [HOLD_W-1:0]  holdoff_len;
    logic               arm;
    logic               disarm;
    logic               irq_ack;
    logic               wrap_clr;
    logic               irq;
    logic [STATE_W-1:0] state;
    logic               wrap_pulse;
    logic               jump_pulse;
    logic [WRAP_W-1:0]  wrap_cnt;

    modport master (
        output cnt_q, threshold, holdoff_len,
        output arm, disarm, irq_ack, wrap_clr,
        input  irq, state, wrap_pulse, jump_pulse, wrap_cnt
    );

    modport slave (
        input  cnt_q, threshold, holdoff_len,
        input  arm, disarm, irq_ack, wrap_clr,
        output irq, state, wrap_pulse, jump_pulse, wrap_cnt
    );
endinterface

// File: rtl/smart_count_monitor_classify.sv
// Holds the previous count sample and classifies each step as hold, +1,
// FF->00 wrap or jump; also flags a fresh landing on the threshold.
module count_step_classify
    import smart_count_monitor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] thr_i,
    output step_e            step_o,
    output logic             match_o
);
    localparam logic [WIDTH-1:0] ALL1 = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_prev_q;
    logic             prev_vld_q;
    logic             wrap_c;
    logic             hold_c;
    logic             inc_c;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            q_prev_q   <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            q_prev_q   <= cnt_i;
            prev_vld_q <= 1'b1;
        end
    end

    // FF->00 is always a wrap, so +1 is restricted to non-FF origins
    assign wrap_c = (q_prev_q == ALL1) && (cnt_i == ZERO);
    assign hold_c = (cnt_i == q_prev_q);
    assign inc_c  = (q_prev_q != ALL1) && (cnt_i == q_prev_q + ONE);

    always_comb begin
        step_o = STEP_NONE;
        if (prev_vld_q) begin
            unique case (1'b1)
                wrap_c:  step_o = STEP_WRAP;
                hold_c:  step_o = STEP_HOLD;
                inc_c:   step_o = STEP_INC;
                default: step_o = STEP_JUMP;
            endcase
        end
    end

    assign match_o = prev_vld_q && !hold_c && (cnt_i == thr_i);

endmodule

// File: rtl/smart_count_monitor.sv
// SmartCounter q-bus monitor: step pulses, saturating wrap tally and an
// arm/fire/ack/holdoff threshold interrupt.
module smart_count_monitor
    import smart_count_monitor_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int WRAP_W = WRAP_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input logic                 clk,
    input logic                 arst,
    smart_count_monitor_if.slave bus
);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    step_e             step;
    logic              match;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              irq_q;
    logic              wrap_p_q;
    logic              jump_p_q;

    count_step_classify #(.WIDTH(WIDTH)) u_classify (
        .clk     (clk),
        .arst    (arst),
        .cnt_i   (bus.cnt_q),
        .thr_i   (bus.threshold),
        .step_o  (step),
        .match_o (match)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            wrap_q   <= '0;
            irq_q    <= 1'b0;
            wrap_p_q <= 1'b0;
            jump_p_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            wrap_q   <= wrap_d;
            irq_q    <= (state_d == ST_FIRED);
            wrap_p_q <= (step == STEP_WRAP);
            jump_p_q <= (step == STEP_JUMP);
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (bus.disarm) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.arm) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (match) state_d = ST_FIRED;
                end
                ST_FIRED: begin
                    if (bus.irq_ack) begin
                        if (bus.holdoff_len == '0) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_HOLDOFF;
                            hold_d  = bus.holdoff_len;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_q <= HOLD_W'(1)) state_d = ST_ARMED;
                    else hold_d = hold_q - HOLD_W'(1);
                end
            endcase
        end
    end

    // clear beats a coincident wrap
    always_comb begin
        wrap_d = wrap_q;
        if (bus.wrap_clr) wrap_d = '0;
        else if (step == STEP_WRAP && wrap_q != WRAP_MAX)
            wrap_d = wrap_q + WRAP_W'(1);
    end

    assign bus.irq        = irq_q;
    assign bus.state      = state_q;
    assign bus.wrap_pulse = wrap_p_q;
    assign bus.jump_pulse = jump_p_q;
    assign bus.wrap_cnt   = wrap_q;

endmodule
